// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: channel count, destination type,
// routing FSM states and the destination one-hot decode.
package demux_pkg;

  localparam int NUM_CH = 16;

  typedef logic [3:0] dest_t;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } route_state_t;

  function automatic logic [NUM_CH-1:0] dest_onehot(input dest_t d);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[d] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/stream_demux16_if.sv
// Handshake bundle between one producer and sixteen consumers of stream_demux16.
interface stream_demux16_if #(parameter int N = 32);
  import demux_pkg::*;

  logic [N-1:0]      in_data;
  dest_t             in_dest;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      out_data;
  logic              out_last;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;

  modport slave (
    input  in_data, in_dest, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

  modport master (
    output in_data, in_dest, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

endinterface

// File: rtl/stream_demux16_skid_buffer.sv
// Two-entry buffer (output register plus one skid entry) whose input ready comes
// straight from a flop, so no consumer ready reaches the producer combinationally.
module skid_buffer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_full,
  input  logic         out_ready
);

  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         out_full_q, out_full_d;
  logic         skid_full_q, skid_full_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain, out_load;

  // The output register takes a new entry whenever it is empty or emptying; the
  // skid entry only ever fills while the output register is stalled.
  always_comb begin
    accept      = in_valid && in_ready_q;
    drain       = out_full_q && out_ready;
    out_load    = !out_full_q || drain;
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    skid_data_d = skid_data_q;
    skid_full_d = skid_full_q;
    if (out_load) begin
      if (skid_full_q) begin
        out_data_d  = skid_data_q;
        out_full_d  = 1'b1;
        skid_full_d = accept;
        if (accept) skid_data_d = in_data;
      end else if (accept) begin
        out_data_d = in_data;
        out_full_d = 1'b1;
      end else begin
        out_full_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d = in_data;
      skid_full_d = 1'b1;
    end
    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
      skid_data_q <= '0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
      skid_data_q <= skid_data_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = out_data_q;
  assign out_full = out_full_q;

endmodule

// File: rtl/stream_demux16.sv
// Packet-aware 1-to-16 stream demultiplexer: locks the destination on a packet's
// first beat, tags each beat with it and buffers through a registered skid stage.
module stream_demux16
  import demux_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_demux16_if.slave        bus,
  output logic                   busy,
  output dest_t                  cur_dest
);

  localparam int W = N + 5;

  route_state_t state_q, state_d;
  dest_t        cur_dest_q, cur_dest_d;
  dest_t        tag_dest;
  dest_t        out_dest;
  logic         accept;
  logic         out_full;
  logic         target_ready;
  logic         skid_ready;
  logic [W-1:0] in_word;
  logic [W-1:0] out_word;

  // Every beat carries its own destination, so the output side never looks at the FSM.
  always_comb begin
    accept     = bus.in_valid && skid_ready;
    tag_dest   = (state_q == IDLE) ? bus.in_dest : cur_dest_q;
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    if (accept) begin
      if (state_q == IDLE) cur_dest_d = bus.in_dest;
      state_d = bus.in_last ? IDLE : PKT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
    end
  end

  assign in_word = {bus.in_data, bus.in_last, tag_dest};

  skid_buffer #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_word),
    .in_valid  (bus.in_valid),
    .in_ready  (skid_ready),
    .out_data  (out_word),
    .out_full  (out_full),
    .out_ready (target_ready)
  );

  assign out_dest      = out_word[3:0];
  assign target_ready  = bus.out_ready[out_dest];
  assign bus.in_ready  = skid_ready;
  assign bus.out_data  = out_word[W-1:5];
  assign bus.out_last  = out_word[4];
  assign bus.out_valid = out_full ? dest_onehot(out_dest) : '0;
  assign busy          = (state_q == PKT);
  assign cur_dest      = cur_dest_q;

endmodule

// File: tb/tb_stream_demux16.sv
// Self-checking bench for stream_demux16: a scoreboard of accepted beats checked
// against delivered beats, plus directed checks of handshake timing and reset.
module tb_stream_demux16;
  import demux_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  busy;
  dest_t cur_dest;

  int    compared = 0;
  int    mismatched = 0;
  int    cycleCount = 0;
  beat_t sbQ[$];
  logic  modelPkt = 1'b0;
  dest_t modelDest = '0;

  stream_demux16_if #(.N(32)) bus ();

  stream_demux16 #(.N(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .cur_dest (cur_dest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Handshakes are sampled mid-cycle; they fire at the following rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      sbQ.delete();
      modelPkt  = 1'b0;
      modelDest = '0;
    end else begin
      if ((bus.out_valid & bus.out_ready) != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_underflow", 64'(bus.out_valid), 64'h0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_valid", 64'(bus.out_valid), 64'(dest_onehot(e.dest)));
          checkOutput("sb_data", 64'(bus.out_data), 64'(e.data));
          checkOutput("sb_last", 64'(bus.out_last), 64'(e.last));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (!modelPkt) modelDest = bus.in_dest;
        e.data = bus.in_data;
        e.last = bus.in_last;
        e.dest = modelDest;
        sbQ.push_back(e);
        modelPkt = !bus.in_last;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] dst, input logic lst);
    int waited = 0;
    bit accepted = 0;
    bus.in_data  = d;
    bus.in_dest  = dst;
    bus.in_last  = lst;
    bus.in_valid = 1'b1;
    while (!accepted && waited < 100) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1;
      else waited++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idleInput();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drainWait();
    int waited = 0;
    while ((sbQ.size() != 0 || bus.out_valid != '0) && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("drain_left", 64'(sbQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 16'hFFFF;

    // Reset values
    waitCycles(3);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cur_dest", 64'(cur_dest), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", 64'(bus.in_ready), 64'd1);

    // Single-beat packet
    applyStimulus(32'hDEADBEEF, 4'd5, 1'b1);
    idleInput();
    checkOutput("single_valid", 64'(bus.out_valid), 64'h0020);
    checkOutput("single_data", 64'(bus.out_data), 64'hDEADBEEF);
    checkOutput("single_last", 64'(bus.out_last), 64'd1);
    checkOutput("single_busy", 64'(busy), 64'd0);
    checkOutput("single_cur_dest", 64'(cur_dest), 64'd5);
    drainWait();

    // Destination lock
    applyStimulus(32'h1000_0001, 4'd3, 1'b0);
    checkOutput("lock_busy1", 64'(busy), 64'd1);
    checkOutput("lock_valid1", 64'(bus.out_valid), 64'h0008);
    applyStimulus(32'h1000_0002, 4'd9, 1'b0);
    checkOutput("lock_busy2", 64'(busy), 64'd1);
    applyStimulus(32'h1000_0003, 4'd9, 1'b0);
    checkOutput("lock_busy3", 64'(busy), 64'd1);
    applyStimulus(32'h1000_0004, 4'd9, 1'b1);
    idleInput();
    checkOutput("lock_busy4", 64'(busy), 64'd0);
    checkOutput("lock_cur_dest", 64'(cur_dest), 64'd3);
    drainWait();

    // Backpressure on channel 3
    bus.out_ready = 16'hFFF7;
    applyStimulus(32'h2000_0001, 4'd3, 1'b0);
    checkOutput("bp_ready1", 64'(bus.in_ready), 64'd1);
    applyStimulus(32'h2000_0002, 4'd3, 1'b0);
    checkOutput("bp_ready_low", 64'(bus.in_ready), 64'd0);
    bus.in_data = 32'h2000_0003;
    waitCycles(3);
    checkOutput("bp_ready_still_low", 64'(bus.in_ready), 64'd0);
    checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'h0008);
    checkOutput("bp_hold_data", 64'(bus.out_data), 64'h2000_0001);
    bus.out_ready = 16'hFFFF;
    waitCycles(1);
    checkOutput("bp_ready_after_drain", 64'(bus.in_ready), 64'd1);
    applyStimulus(32'h2000_0003, 4'd3, 1'b0);
    applyStimulus(32'h2000_0004, 4'd3, 1'b0);
    applyStimulus(32'h2000_0005, 4'd3, 1'b0);
    applyStimulus(32'h2000_0006, 4'd3, 1'b1);
    idleInput();
    drainWait();

    // Back-to-back packets, one beat per cycle
    c0 = cycleCount;
    applyStimulus(32'h3000_0001, 4'd0, 1'b0);
    checkOutput("b2b_valid1", 64'(bus.out_valid), 64'h0001);
    applyStimulus(32'h3000_0002, 4'd0, 1'b1);
    checkOutput("b2b_valid2", 64'(bus.out_valid), 64'h0001);
    applyStimulus(32'h3000_0003, 4'd15, 1'b0);
    checkOutput("b2b_valid3", 64'(bus.out_valid), 64'h8000);
    applyStimulus(32'h3000_0004, 4'd15, 1'b1);
    checkOutput("b2b_valid4", 64'(bus.out_valid), 64'h8000);
    checkOutput("b2b_cycles", 64'(cycleCount - c0), 64'd4);
    idleInput();
    drainWait();

    // Only a non-target channel is ready
    bus.out_ready = 16'h0080;
    applyStimulus(32'h4444_2222, 4'd2, 1'b1);
    idleInput();
    checkOutput("wrong_valid", 64'(bus.out_valid), 64'h0004);
    waitCycles(3);
    checkOutput("wrong_hold_valid", 64'(bus.out_valid), 64'h0004);
    checkOutput("wrong_hold_data", 64'(bus.out_data), 64'h4444_2222);
    bus.out_ready = 16'h0004;
    waitCycles(1);
    checkOutput("wrong_delivered", 64'(bus.out_valid), 64'h0000);
    bus.out_ready = 16'hFFFF;
    drainWait();

    // Reset in the middle of a packet
    bus.out_ready = 16'h0000;
    applyStimulus(32'h5000_0001, 4'd4, 1'b0);
    applyStimulus(32'h5000_0002, 4'd4, 1'b0);
    idleInput();
    checkOutput("mid_valid", 64'(bus.out_valid), 64'h0010);
    checkOutput("mid_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'h0000);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("mid_rst_cur_dest", 64'(cur_dest), 64'd0);
    waitCycles(2);
    bus.out_ready = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(32'h6000_000B, 4'd11, 1'b1);
    idleInput();
    checkOutput("post_rst_valid", 64'(bus.out_valid), 64'h0800);
    checkOutput("post_rst_data", 64'(bus.out_data), 64'h6000_000B);
    drainWait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_demux16.md
# stream_demux16

Packet-aware 1-to-16 stream demultiplexer: the write-side counterpart of `mux16`, used wherever one producer must fan out to sixteen consumers. A valid/ready stream enters on one port. The block latches the destination channel on the first beat of each packet and routes every beat to that channel until the `last` beat. The output is registered, and the input `ready` is registered behind a skid stage. Full throughput of one beat per cycle is sustained with no combinational ready path from any consumer to the producer.

## Interface
- `N`, default 32: data width in bits.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_data` input N: beat payload.
- `in_dest` input 4: destination channel; sampled only on the first beat of a packet.
- `in_last` input 1: marks the final beat of a packet.
- `in_valid` input 1: producer has a beat.
- `in_ready` output 1: block accepts a beat; driven directly from a flop.
- `out_data` output N: payload broadcast to all channels.
- `out_last` output 1: the last flag of the current output beat.
- `out_valid` output 16: one-hot; bit k set when the beat is for channel k.
- `out_ready` input 16: per-channel consumer ready.
- `busy` output 1: a packet is open, meaning the first beat was accepted and the last beat was not yet accepted.
- `cur_dest` output 4: the locked destination while `busy`; otherwise the destination of the last packet.

## Operation
- An input beat is accepted when `in_valid && in_ready` at a rising edge. An output beat is delivered when `out_valid[k] && out_ready[k]` for the single active k.
- The routing FSM has two states, IDLE and PKT. Both update only on accepted input beats.
  - In IDLE, an accepted beat uses `in_dest` as its destination and loads `cur_dest`.
  - From IDLE, if `in_last`=0 the FSM moves to PKT and `busy`=1. If `in_last`=1 the packet has one beat and the FSM stays in IDLE.
  - In PKT, `in_dest` is ignored and the beat is tagged with `cur_dest`. An accepted beat with `in_last`=1 returns the FSM to IDLE and clears `busy`.
- Each buffered entry stores {data, last, dest}. The dest is fixed at acceptance, so the output side never consults the FSM.
- Buffering is two entries: an output register plus one skid entry.
  - `in_ready` is registered and equals "skid entry empty" for the next cycle.
  - When the output register is empty or being drained, the incoming beat goes to the output register. Otherwise it goes to the skid entry.
  - On a drain, the skid entry moves into the output register.
- `out_valid` = the decoded one-hot of the dest in the output register, gated by "output register full". Ready bits of non-target channels are ignored.
- Beat order is strictly preserved. No beat is ever dropped or duplicated.
- There is no timeout and no error flag. A producer that never sends `last` keeps `busy` high indefinitely.

## Timing
- Reset values while `rst_n`=0:
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
  - `busy`=0, `cur_dest`=0, FSM in IDLE, both buffer entries empty.
- `in_ready` rises at the first rising edge after `rst_n` is released.
- Latency: a beat accepted at edge t is presented on `out_*` from t+1, when the output register was empty.
- Throughput: with the target ready held high, one beat per cycle is sustained, including back-to-back packets to different channels with no gap cycle.
- Backpressure: with the target not ready, two more beats are accepted and then `in_ready`=0 from the following cycle. `in_ready` returns to 1 the cycle after the first drain.
- Simultaneous accept and drain in the same cycle is legal and must not change occupancy.
- Reset asserted mid-packet: all outputs clear immediately (asynchronously). Buffered beats are discarded. The next accepted beat after release is treated as a first beat.
- `out_data` and `out_last` are held stable while `out_valid` is nonzero and the target is not ready.

## Structure
- The shared package `demux_pkg` holds `NUM_CH`=16, `dest_t` (logic [3:0]), and the enum `route_state_t` {IDLE, PKT}.
- Sub-module `skid_buffer` (parameter W) holds the two-entry output register plus skid entry, with a registered input ready.
- `stream_demux16` instantiates `skid_buffer` with W=N+5. It contains the FSM, the dest tagging logic and the one-hot decode.

## Test plan
- Single-beat packet: `in_dest`=5, data 0xDEADBEEF, `in_last`=1, all `out_ready`=1 -> next cycle `out_valid`=16'h0020, `out_data`=0xDEADBEEF, `out_last`=1; `busy` stays 0.
- Destination lock: 4-beat packet starting with `in_dest`=3, with `in_dest` switched to 9 on beats 2-4 -> all four beats appear on channel 3 (`out_valid`=16'h0008) in order. `busy` is 1 from beat 1 until the edge that accepts beat 4.
- Backpressure: stream 6 beats to channel 3 with `out_ready[3]`=0 for 5 cycles -> `in_ready` falls after 2 beats are accepted. After release, all 6 beats arrive in order with no loss.
- Back-to-back packets: a 2-beat packet to channel 0 immediately followed by a 2-beat packet to channel 15, no idle cycles -> 4 consecutive output cycles with `out_valid` = 0x0001, 0x0001, 0x8000, 0x8000.
- Wrong-channel ready: beat queued for channel 2 with only `out_ready[7]`=1 -> beat held on the output; `out_data` stable; it is delivered once `out_ready[2]`=1.
- Reset mid-packet: assert `rst_n`=0 after beat 2 of a 4-beat packet to channel 4 -> `out_valid`=0, `busy`=0 immediately. After release, a beat with `in_dest`=11 routes to channel 11.
